sign_extend_pipe: RTL and testbench
===================================

# sign_extend_pipe

Parametrised, registered sign/zero-extension stage for the 16-bit accumulator datapath. Takes an IN_W-bit immediate field with a per-transaction field width and extension mode, and produces an OUT_W-bit operand. It replaces fixed single-bit extension with a valid/ready pipeline stage that sits between instruction decode and the ALU operand mux, and it sustains one transaction per clock under backpressure.

## Interface
- IN_W, 12, width of the incoming immediate bus (1..OUT_W)
- OUT_W, 16, width of the extended result (≥ IN_W)
- WS_W, $clog2(IN_W+1), width of the field-width selector
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream transaction valid
- in_ready  out  1  stage can accept; registered output, no combinational path from out_ready
- in_data  in  IN_W  immediate bits; field occupies bits [w-1:0]
- in_width  in  WS_W  field width w in bits
- in_signed  in  1  1 = sign-extend from bit w-1; 0 = zero-extend
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  OUT_W  extended result
- out_neg  out  1  out_data[OUT_W-1]
- out_err  out  1  in_width was out of range (0 or > IN_W) for this transaction

## Operation
- Transfer on the input occurs when in_valid && in_ready. Transfer on the output occurs when out_valid && out_ready.
- Effective width: we = in_width clamped to IN_W. If in_width = 0, the result is all zeros.
- Result bit i is in_data[i] for i < we. For i ≥ we, it is in_data[we-1] if in_signed, else 0.
- Bits of in_data at or above we are ignored. They must not affect the result.
- out_err = (in_width == 0) || (in_width > IN_W). It travels with its transaction.
- Buffering: a main output register plus one skid register, for two entries total.
  - in_ready = skid register empty.
  - When out_ready is low and the main register is full, an accepted transaction goes into the skid register.
  - When out_ready is high, the skid contents move to the main register on the next edge.
- Order is strictly FIFO. There is no drop and no duplication.
- Simultaneous accept and drain with the main register full and the skid empty: the new data replaces the main register. Throughput is 1/clk.
- The payload registers (data, neg, err) load only on accept, so there are no spurious toggles.

## Timing
- Latency: a transaction accepted at edge N appears on out_* after edge N (one cycle).
- Reset values: out_valid=0, in_ready=1 (from the first cycle after reset), out_data=0, out_neg=0, out_err=0, skid empty.
- Reset mid-operation clears both entries. Any in-flight transactions are discarded, not emitted.
- out_data, out_neg and out_err stay stable while out_valid && !out_ready.
- in_ready falls one cycle after the skid register fills. It rises one cycle after the skid drains.
- After out_ready deasserts, the stage accepts at most one more transaction.

## Structure
- Shared package sext_pkg holds:
  - function ext_field(data, width, signed_mode) returning OUT_W bits, including the clamp and zero-width rules
  - localparam default widths IN_W_DEF=12, OUT_W_DEF=16
- Sub-module sext_skid_buf: a generic 2-entry valid/ready skid buffer, parametrised on payload width (OUT_W+2). The top level computes ext_field combinationally on the input side and feeds the payload into the skid buffer.
- Only combinational extension logic lives in the top level. All state lives in sext_skid_buf.

## Test plan
- Reset release, out_ready=1: send data=0x0800, w=12, signed=1 → out_data=0xF800, out_neg=1, out_err=0, one cycle after accept. Then send the same with signed=0 → 0x0800, out_neg=0.
- Width sweep: data=0xFFF, w=1..12, signed=1 → 0xFFFF every time. data=0x7FF, w=12 → 0x07FF. data=0x005, w=3, signed=1 → 0xFFFD; signed=0 → 0x0005. Garbage in the bits above w is ignored.
- Out-of-range width: w=0 → out_data=0x0000, out_err=1. w=15, data=0x800, signed=1 → clamps to 12, giving 0xF800 with out_err=1.
- Backpressure: stream values 1..8 with out_ready low for 3 cycles mid-stream:
  - in_ready drops after exactly one extra accept
  - outputs are held stable
  - all 8 values emerge in order, with none lost or duplicated
- Full throughput: in_valid=1 and out_ready=1 continuously for 16 cycles → 16 results on consecutive cycles, and in_ready never drops.
- Reset mid-operation: with both entries full, assert rst for one cycle → out_valid=0 and in_ready=1 the next cycle, and neither held value appears afterwards.

Source files
------------

// File: rtl/sext_pkg.sv
// Shared definitions for the sign/zero-extension pipeline stage.
// ext_field works on a wide fixed vector so any IN_W/OUT_W up to EXT_MAX_W can use it.
package sext_pkg;

  localparam int IN_W_DEF  = 12;
  localparam int OUT_W_DEF = 16;
  localparam int EXT_MAX_W = 64;

  // Width is clamped to in_w; a zero width yields all zeros.
  function automatic logic [EXT_MAX_W-1:0] ext_field(
    input logic [EXT_MAX_W-1:0] data,
    input int unsigned          width,
    input int unsigned          in_w,
    input logic                 signed_mode
  );
    int unsigned          we;
    logic [EXT_MAX_W-1:0] mask;
    logic [EXT_MAX_W-1:0] msb_vec;
    logic                 fill;
    we = (width > in_w) ? in_w : width;
    ext_field = '0;
    if (we != 0) begin
      mask    = ~({EXT_MAX_W{1'b1}} << we);
      msb_vec = data >> (we - 1);
      fill    = signed_mode & msb_vec[0];
      ext_field = (data & mask) | (fill ? ~mask : '0);
    end
  endfunction

endpackage

// File: rtl/sext_skid_buf.sv
// Generic two-entry valid/ready skid buffer: a main output register plus one skid register.
// Handshake: a beat transfers on a side when its valid and ready are both high at a rising edge.
module sext_skid_buf #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept, drain;

  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    accept     = in_valid && !skid_vld_q;
    drain      = main_vld_q && out_ready;
    if (!main_vld_q || drain) begin
      // Main slot frees up: the older skid entry has priority to keep FIFO order.
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = in_data;
      end
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_d     = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = !skid_vld_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_q;

endmodule

// File: rtl/sign_extend_pipe.sv
// Registered sign/zero-extension stage: extends a variable-width immediate field to OUT_W bits.
// Extension is combinational on the input side; all state lives in the skid buffer.
module sign_extend_pipe
  import sext_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int WS_W  = $clog2(IN_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [WS_W-1:0]  in_width,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg,
  output logic             out_err
);

  localparam int PW = OUT_W + 2;

  logic [OUT_W-1:0] ext_d;
  logic             err_d;
  logic [PW-1:0]    pay_in;
  logic [PW-1:0]    pay_out;

  always_comb begin
    ext_d  = OUT_W'(ext_field(EXT_MAX_W'(in_data), 32'(in_width), 32'(IN_W), in_signed));
    err_d  = (in_width == '0) || (in_width > WS_W'(IN_W));
    pay_in = {err_d, ext_d[OUT_W-1], ext_d};
  end

  sext_skid_buf #(.W(PW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  assign {out_err, out_neg, out_data} = pay_out;

endmodule

// File: tb/tb_sign_extend_pipe.sv
// Bench for sign_extend_pipe: directed cases, backpressure, throughput, random traffic, mid-run reset.
module tb_sign_extend_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic [3:0]  in_width;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_neg;
  logic        out_err;

  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;
  logic [17:0] exp_q[$];
  logic [17:0] held;
  bit          hold_pending = 0;

  sign_extend_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_width  (in_width),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_neg   (out_neg),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: keep the low we bits, then reinterpret as a two's-complement number if signed.
  function automatic logic [17:0] model(input logic [11:0] d, input int w, input logic s);
    int          we;
    int unsigned field;
    int unsigned r;
    logic        err;
    we  = (w > 12) ? 12 : w;
    err = (w == 0) || (w > 12);
    if (we == 0) r = 0;
    else begin
      field = int'(d) % (1 << we);
      if (s && field >= (1 << (we - 1))) r = field + 65536 - (1 << we);
      else r = field;
    end
    return {err, r[15], r[15:0]};
  endfunction

  // Drive one cycle starting at posedge+1, score transfers, advance to the next posedge+1.
  task automatic cycle(input logic v, input logic [11:0] d, input logic [3:0] w,
                       input logic s, input logic ordy);
    logic [17:0] got;
    in_valid = v; in_data = d; in_width = w; in_signed = s; out_ready = ordy;
    #1;
    got = {out_err, out_neg, out_data};
    if (hold_pending) check("hold_stable", {13'd0, out_valid, got}, {13'd1, held});
    if (out_valid && out_ready) begin
      check("out_queue_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("out_payload", got, exp_q.pop_front());
      n_out++;
    end
    hold_pending = out_valid && !out_ready;
    held = got;
    if (v && in_ready) exp_q.push_back(model(d, int'(w), s));
    @(posedge clk);
    #1;
  endtask

  task automatic send_dir(input string tag, input logic [11:0] d, input logic [3:0] w,
                          input logic s, input logic [15:0] ed, input logic ee);
    cycle(1'b1, d, w, s, 1'b1);
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_data"}, out_data, ed);
    check({tag, "_neg"}, out_neg, ed[15]);
    check({tag, "_err"}, out_err, ee);
    cycle(1'b0, 12'd0, 4'd0, 1'b0, 1'b1);
  endtask

  initial begin
    int base, idx, stall_acc, drops;
    bit acc_now;
    logic v, ordy;

    rst = 1'b1; in_valid = 0; in_data = 0; in_width = 0; in_signed = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_neg", out_neg, 0);
    check("rst_out_err", out_err, 0);

    send_dir("s12", 12'h800, 4'd12, 1'b1, 16'hF800, 1'b0);
    send_dir("u12", 12'h800, 4'd12, 1'b0, 16'h0800, 1'b0);
    for (int w = 1; w <= 12; w++) send_dir("sweep", 12'hFFF, 4'(w), 1'b1, 16'hFFFF, 1'b0);
    send_dir("pos12", 12'h7FF, 4'd12, 1'b1, 16'h07FF, 1'b0);
    send_dir("s3", 12'h005, 4'd3, 1'b1, 16'hFFFD, 1'b0);
    send_dir("u3", 12'h005, 4'd3, 1'b0, 16'h0005, 1'b0);
    send_dir("junk_s3", 12'hAB5, 4'd3, 1'b1, 16'hFFFD, 1'b0);
    send_dir("junk_u3", 12'hAB5, 4'd3, 1'b0, 16'h0005, 1'b0);
    send_dir("w0", 12'hFFF, 4'd0, 1'b1, 16'h0000, 1'b1);
    send_dir("w15", 12'h800, 4'd15, 1'b1, 16'hF800, 1'b1);

    // Backpressure: out_ready low for cycles 3..5 while streaming 1..8.
    base = n_out; idx = 0; stall_acc = 0;
    for (int c = 0; c < 40 && (n_out - base) < 8; c++) begin
      ordy = !(c >= 3 && c < 6);
      v = (idx < 8);
      acc_now = v && in_ready;
      if (acc_now && !ordy) stall_acc++;
      if (c >= 4 && c <= 6) check("bp_ready_low", in_ready, 0);
      if (c == 7) check("bp_ready_back", in_ready, 1);
      cycle(v, 12'(idx + 1), 4'd12, 1'b0, ordy);
      if (acc_now) idx++;
    end
    check("bp_extra_accepts", stall_acc, 1);
    check("bp_count", n_out - base, 8);
    check("bp_queue_empty", exp_q.size(), 0);

    // Full throughput.
    base = n_out; drops = 0;
    for (int i = 0; i < 16; i++) begin
      if (!in_ready) drops++;
      cycle(1'b1, 12'($urandom), 4'($urandom_range(12, 1)), 1'($urandom), 1'b1);
    end
    cycle(1'b0, 12'd0, 4'd0, 1'b0, 1'b1);
    check("tput_count", n_out - base, 16);
    check("tput_ready_drops", drops, 0);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom), 12'($urandom), 4'($urandom_range(15, 0)), 1'($urandom),
            ($urandom_range(3, 0) != 0));
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle(1'b0, 12'd0, 4'd0, 1'b0, 1'b1);
    check("rand_drain_empty", exp_q.size(), 0);

    // Reset with both entries occupied.
    cycle(1'b1, 12'h123, 4'd12, 1'b1, 1'b0);
    cycle(1'b1, 12'h456, 4'd12, 1'b1, 1'b0);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    hold_pending = 0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_data", out_data, 0);
    base = n_out;
    repeat (4) cycle(1'b0, 12'd0, 4'd0, 1'b0, 1'b1);
    check("mid_rst_no_output", n_out - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
